// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, control states and the C/Z flag pair.
`timescale 1ns/1ps
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBC = 4'd3,
    OP_CMP  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_EXOR = 4'd7,
    OP_TEST = 4'd8,
    OP_LSL  = 4'd9,
    OP_LSR  = 4'd10,
    OP_ROL  = 4'd11,
    OP_ROR  = 4'd12,
    OP_ASR  = 4'd13,
    OP_MOV  = 4'd14,
    OP_MUL  = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

  // CMP and TEST only produce flags; everything else writes its result back.
  function automatic logic is_writeback(input opcode_e op);
    return !((op == OP_CMP) || (op == OP_TEST));
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
`timescale 1ns/1ps
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic                 busy_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   acc_next;

  // done and product reflect the final accumulation so the caller can register
  // the product on the same edge the last partial product is added.
  always_comb begin
    acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    done     = busy_reg && (cnt_reg == CNT_W'(WIDTH - 1));
    product  = acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg   <= 1'b0;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else if (start) begin
      busy_reg   <= 1'b1;
      cnt_reg    <= '0;
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      acc_reg    <= '0;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
      if (done) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes, architectural C/Z flags and an
// interrupt shadow copy of the flags; MUL runs on the iterative multiplier.
`timescale 1ns/1ps
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wb_en,
  output logic             c_flag,
  output logic             z_flag,
  input  logic             flg_save,
  input  logic             flg_restore
);

  state_e             state_reg, state_next;
  logic [WIDTH-1:0]   result_reg;
  logic               wb_en_reg;
  flags_t             pend_reg;
  flags_t             flags_reg;
  flags_t             shadow_reg;

  opcode_e            op;
  logic               is_mul;
  logic               accept;
  logic               handshake;
  logic               cin;
  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign op        = opcode_e'(sel);
  assign is_mul    = MUL_EN && (op == OP_MUL);
  assign out_valid = (state_reg == ST_DONE);
  assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  // A result retiring this cycle has not reached flags_reg yet, so take its carry directly.
  assign cin       = handshake ? pend_reg.c : flags_reg.c;

  assign result = result_reg;
  assign wb_en  = wb_en_reg;
  assign c_flag = flags_reg.c;
  assign z_flag = flags_reg.z;

  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD:  begin ext = {1'b0, a} + {1'b0, b};                           alu_res = ext[WIDTH-1:0]; alu_c = ext[WIDTH]; end
      OP_ADDC: begin ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};    alu_res = ext[WIDTH-1:0]; alu_c = ext[WIDTH]; end
      OP_SUB,
      OP_CMP:  begin ext = {1'b0, a} - {1'b0, b};                           alu_res = ext[WIDTH-1:0]; alu_c = ext[WIDTH]; end
      OP_SUBC: begin ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};    alu_res = ext[WIDTH-1:0]; alu_c = ext[WIDTH]; end
      OP_AND,
      OP_TEST: alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_EXOR: alu_res = a ^ b;
      OP_LSL:  begin alu_res = {a[WIDTH-2:0], cin};        alu_c = a[WIDTH-1]; end
      OP_LSR:  begin alu_res = {cin, a[WIDTH-1:1]};        alu_c = a[0];       end
      OP_ROL:  begin alu_res = {a[WIDTH-2:0], a[WIDTH-1]}; alu_c = a[WIDTH-1]; end
      OP_ROR:  begin alu_res = {a[0], a[WIDTH-1:1]};       alu_c = a[0];       end
      OP_ASR:  begin alu_res = {a[WIDTH-1], a[WIDTH-1:1]}; alu_c = a[0];       end
      // MOV passes operand B; MUL lands here too when the multiplier is disabled.
      default: alu_res = b;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = is_mul ? ST_BUSY : ST_DONE;
      ST_BUSY: if (mul_done) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = accept ? (is_mul ? ST_BUSY : ST_DONE) : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg <= '0;
      wb_en_reg  <= 1'b0;
      pend_reg   <= '0;
      flags_reg  <= '0;
      shadow_reg <= '0;
    end else begin
      if (accept && !is_mul) begin
        result_reg <= alu_res;
        wb_en_reg  <= is_writeback(op);
        pend_reg.c <= alu_c;
        pend_reg.z <= (alu_res == '0);
      end else if (mul_done) begin
        result_reg <= mul_product[WIDTH-1:0];
        wb_en_reg  <= 1'b1;
        pend_reg.c <= |mul_product[2*WIDTH-1:WIDTH];
        pend_reg.z <= (mul_product[WIDTH-1:0] == '0);
      end
      // Restore is written last so it overrides a same-cycle retirement; save
      // reads the pre-update flags, which also makes save+restore a swap.
      if (handshake) begin
        flags_reg <= pend_reg;
      end
      if (flg_restore) begin
        flags_reg <= shadow_reg;
      end
      if (flg_save) begin
        shadow_reg <= flags_reg;
      end
    end
  end

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data path width (>=4).
REQ-002 SHALL have parameter MUL_EN, default 1; when 0, SEL=15 executes as MOV.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports A, B  input  WIDTH  operands, sampled on accept.
REQ-006 SHALL have port SEL  input  4  opcode: 0 ADD, 1 ADDC, 2 SUB, 3 SUBC, 4 CMP, 5 AND, 6 OR, 7 EXOR, 8 TEST, 9 LSL, 10 LSR, 11 ROL, 12 ROR, 13 ASR, 14 MOV, 15 MUL.
REQ-007 SHALL have ports IN_VALID input 1 and IN_READY output 1: operation request handshake.
REQ-008 SHALL have ports OUT_VALID output 1 and OUT_READY input 1: result handshake.
REQ-009 SHALL have port RESULT  output  WIDTH  registered result.
REQ-010 SHALL have port WB_EN  output  1  result is to be written back (0 for CMP, TEST).
REQ-011 SHALL have ports C_FLAG, Z_FLAG  output  1  architectural flag registers.
REQ-012 SHALL have ports FLG_SAVE, FLG_RESTORE  input  1  single-cycle pulses for interrupt flag shadow.

Function
REQ-013 SHALL implement FSM IDLE -> (accept, non-MUL) DONE; IDLE -> (accept, MUL) BUSY; BUSY -> (WIDTH iterations complete) DONE; DONE -> (OUT_READY, no new accept) IDLE; DONE -> (OUT_READY and accept) DONE or BUSY.
REQ-014 SHALL accept when IN_VALID && IN_READY; IN_READY = (state==IDLE) || (state==DONE && OUT_READY).
REQ-015 SHALL assert OUT_VALID exactly while in DONE; latency accept->OUT_VALID: 1 cycle non-MUL, WIDTH+1 cycles MUL.
REQ-016 SHALL hold RESULT, WB_EN and pending flags stable while OUT_VALID && !OUT_READY.
REQ-017 SHALL compute arithmetic in WIDTH+1 bits; C = bit WIDTH (borrow for SUB/SUBC/CMP); Z = (RESULT==0).
REQ-018 SHALL use C_FLAG as carry-in for ADDC, SUBC, LSL, LSR; when accept coincides with a DONE handshake, SHALL forward the pending C instead.
REQ-019 SHALL implement logic ops with C=0; shifts/rotates with C = bit shifted out (ROL/LSL: A[WIDTH-1]; ROR/LSR/ASR: A[0]); MOV: C=0.
REQ-020 SHALL implement MUL as iterative shift-add, one partial product per cycle; RESULT = low WIDTH bits; C = 1 iff high WIDTH bits nonzero.
REQ-021 SHALL update C_FLAG/Z_FLAG only on the output handshake (OUT_VALID && OUT_READY), for every opcode.
REQ-022 SHALL on FLG_SAVE copy current C_FLAG/Z_FLAG (pre-update values) into shadow.
REQ-023 SHALL on FLG_RESTORE load flags from shadow, overriding a same-cycle handshake update.
REQ-024 SHALL, on FLG_SAVE and FLG_RESTORE together, swap flags and shadow.
REQ-025 SHALL ignore IN_VALID while IN_READY=0 (no queuing).

Reset
REQ-026 SHALL on RST force state IDLE and RESULT, WB_EN, OUT_VALID, C_FLAG, Z_FLAG, shadow, multiplier state to 0, IN_READY=1 the following cycle.
REQ-027 SHALL abort any in-flight MUL or pending result on RST without flag update; RST overrides all other inputs.

Structure
REQ-028 SHALL place opcode enum, FSM state enum and flag struct in shared package alu_pkg.
REQ-029 SHALL contain one sub-module alu_mul_iter (start, operands, done, 2*WIDTH product).

Verification (WIDTH=8)
REQ-030 SHALL cover: ADD A=0xFF B=0x01 -> next cycle OUT_VALID=1, RESULT=0x00; after handshake C=1, Z=1.
REQ-031 SHALL cover: ADDC A=0x10 B=0x20 accepted in the same cycle as the REQ-030 handshake -> RESULT=0x31 (forwarded C).
REQ-032 SHALL cover: MUL 0x0F*0x03 -> OUT_VALID after 9 cycles, RESULT=0x2D, C=0; MUL 0x10*0x20 -> RESULT=0x00, C=1, Z=1.
REQ-033 SHALL cover: OUT_READY low 3 cycles -> RESULT, OUT_VALID stable, IN_READY=0, flags unchanged.
REQ-034 SHALL cover: flags C=1 Z=0, FLG_SAVE, CMP 0x05,0x05 (WB_EN=0, Z=1, C=0), FLG_RESTORE -> C=1, Z=0.
REQ-035 SHALL cover: RST asserted in 4th BUSY cycle of MUL -> next cycle OUT_VALID=0, IN_READY=1, all flags 0.
